// File: rtl/regfile_fib_checker_pkg.sv
// Purpose : shared types/constants for the Fibonacci register-file generator/checker pair.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: 3-bit scan-state enum, default address/data widths.
package regfile_fib_checker_pkg;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRIME0 = 3'd1,
    ST_PRIME1 = 3'd2,
    ST_CHECK  = 3'd3,
    ST_EMIT   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/regfile_fib_checker.sv
// Purpose : walks a register file read port over [START_ADDR..END_ADDR], checks each word
//           equals the wrapping sum of the two words before it, streams word+flag out.
// Latency : start edge k -> last handshake/done at k+2+2*(END_ADDR-START_ADDR+1) with ready high.
// Backpressure: out_ready low holds out_*, raddr and the prev window; the scan simply stalls.
// Ports:
//   clk, rst (async, active-high)     start        : one-cycle scan request (IDLE/DONE only)
//   raddr -> / rdata <- : register-file read port, rdata combinational from raddr
//   out_valid/out_ready/out_data/out_addr/out_mismatch : checked-entry stream
//   busy, done, err_flag, err_count (saturating), first_err_addr : scan status
module regfile_fib_checker
  import regfile_fib_checker_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int START_ADDR = 2,
  parameter int END_ADDR   = 63
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_mismatch,
  output logic              busy,
  output logic              done,
  output logic              err_flag,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam logic [ADDR_W-1:0] SEED_A = ADDR_W'(START_ADDR - 2);
  localparam logic [ADDR_W-1:0] END_A  = ADDR_W'(END_ADDR);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] prev1, prev2;
  logic [DATA_W-1:0] exp_sum;
  logic              mismatch;
  logic              last_entry;

  // Carry out of the add is dropped: the generator fills the file mod 2^DATA_W.
  assign exp_sum    = prev2 + prev1;
  assign mismatch   = (rdata != exp_sum);
  assign last_entry = (out_addr == END_A);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE, ST_DONE: if (start) state_nxt = ST_PRIME0;
      ST_PRIME0:        state_nxt = ST_PRIME1;
      ST_PRIME1:        state_nxt = ST_CHECK;
      ST_CHECK:         state_nxt = ST_EMIT;
      ST_EMIT:          if (out_ready) state_nxt = last_entry ? ST_DONE : ST_CHECK;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  // Decoded from state so that an async reset drops out_valid/busy immediately.
  always_comb begin
    busy      = (state == ST_PRIME0) || (state == ST_PRIME1) ||
                (state == ST_CHECK)  || (state == ST_EMIT);
    done      = (state == ST_DONE);
    out_valid = (state == ST_EMIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raddr          <= '0;
      out_data       <= '0;
      out_addr       <= '0;
      out_mismatch   <= 1'b0;
      err_flag       <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      prev1          <= '0;
      prev2          <= '0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            raddr          <= SEED_A;
            err_flag       <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
          end
        end
        ST_PRIME0: begin
          prev2 <= rdata;
          raddr <= raddr + 1'b1;
        end
        ST_PRIME1: begin
          prev1 <= rdata;
          raddr <= raddr + 1'b1;
        end
        ST_CHECK: begin
          out_data     <= rdata;
          out_addr     <= raddr;
          out_mismatch <= mismatch;
          if (mismatch) begin
            err_flag <= 1'b1;
            if (!err_flag) first_err_addr <= raddr;
            if (err_count != '1) err_count <= err_count + 1'b1;
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            // Shift in the word actually read, so a corrupt entry feeds the next two checks.
            prev2 <= prev1;
            prev1 <= out_data;
            if (!last_entry) raddr <= raddr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_fib_checker.sv
module tb_regfile_fib_checker;

  localparam int AW   = 6;
  localparam int DW   = 32;
  localparam int SA   = 2;
  localparam int EA   = 63;
  localparam int NENT = EA - SA + 1;
  localparam int BASE = 2 + 2 * NENT;   // 126 edges from start to done

  logic          clk = 1'b0;
  logic          rst, start, out_ready;
  logic [AW-1:0] raddr, out_addr, first_err_addr;
  logic [DW-1:0] rdata, out_data;
  logic          out_valid, out_mismatch, busy, done, err_flag;
  logic [AW:0]   err_count;

  logic [DW-1:0] mem [64];
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  assign rdata = mem[raddr];

  regfile_fib_checker dut (
    .clk(clk), .rst(rst), .start(start), .raddr(raddr), .rdata(rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .out_mismatch(out_mismatch), .busy(busy), .done(done),
    .err_flag(err_flag), .err_count(err_count), .first_err_addr(first_err_addr)
  );

  typedef struct {
    int          corrupt_addr;   // -1: none
    logic [31:0] mask;
    int          stall_addr;
    int          stall_len;
    int          rst_addr;       // -1: no reset
    int          restart_addr;   // -1: no mid-scan start pulse
    int          exp_cnt;
    int          exp_first;
    int          exp_cycles;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fill_fib();
    mem[0] = 0;
    mem[1] = 1;
    for (int i = 2; i < 64; i++) mem[i] = mem[i-1] + mem[i-2];
  endtask

  // Reference: an entry is bad if it differs from the 32-bit sum of the two stored words before it.
  function automatic bit exp_mis(input int a);
    logic [DW-1:0] s;
    s = mem[a-1] + mem[a-2];
    return mem[a] != s;
  endfunction

  task automatic model(output int cnt, output int first);
    cnt = 0;
    first = -1;
    for (int a = SA; a <= EA; a++) begin
      if (exp_mis(a)) begin
        if (first < 0) first = a;
        cnt++;
      end
    end
  endtask

  task automatic run_scan(input int stall_addr, input int stall_len, input int rst_addr,
                          input int restart_addr, output int cyc_done);
    int cyc, nexp, last_hs, seen, stalled;
    bit restarted;
    logic prev_busy;
    logic [DW-1:0] hold_data;
    logic [AW-1:0] hold_addr, hold_raddr;
    cyc_done = -1;
    nexp = SA; last_hs = 1; seen = -1; stalled = 0; restarted = 0;
    hold_data = '0; hold_addr = '0; hold_raddr = '0;
    @(posedge clk); #1;
    start = 1; out_ready = 1;
    @(posedge clk); #1;               // start accepted on this edge (k)
    start = 0;
    chk("start_busy", busy, 1);
    chk("start_clr_count", err_count, 0);
    chk("start_clr_flag", err_flag, 0);
    chk("start_clr_done", done, 0);
    cyc = 0;
    prev_busy = busy;
    while (cyc < 400) begin
      start = 0;
      if (done) begin
        chk("busy_fall_with_done", busy, 0);
        chk("busy_before_done", prev_busy, 1);
        chk("all_entries_seen", nexp, EA + 1);
        chk("raddr_at_end", raddr, EA);
        cyc_done = cyc;
        break;
      end
      if (out_valid) begin
        if (int'(out_addr) == rst_addr) begin
          #2 rst = 1;
          #1;
          chk("rst_out_valid", out_valid, 0);
          chk("rst_busy", busy, 0);
          chk("rst_done", done, 0);
          chk("rst_err_flag", err_flag, 0);
          chk("rst_err_count", err_count, 0);
          chk("rst_first_err", first_err_addr, 0);
          chk("rst_raddr", raddr, 0);
          chk("rst_out_addr", out_addr, 0);
          @(posedge clk); #1;
          rst = 0; out_ready = 1;
          cyc_done = -2;
          return;
        end
        if (int'(out_addr) != seen) begin
          chk("entry_latency", cyc, last_hs + 2);
          seen = out_addr;
        end
        if (int'(out_addr) == stall_addr && stalled > 0) begin
          chk("stall_hold_data", out_data, hold_data);
          chk("stall_hold_addr", out_addr, hold_addr);
          chk("stall_hold_raddr", raddr, hold_raddr);
        end
        if (int'(out_addr) == stall_addr && stalled < stall_len) begin
          if (stalled == 0) begin
            hold_data = out_data; hold_addr = out_addr; hold_raddr = raddr;
          end
          out_ready = 0;
          stalled++;
        end else begin
          out_ready = 1;
        end
        if (int'(out_addr) == restart_addr && !restarted) begin
          start = 1;
          restarted = 1;
        end
        if (out_ready) begin
          chk("hs_addr", out_addr, nexp);
          if (nexp <= EA) begin
            chk("hs_data", out_data, mem[nexp]);
            chk("hs_mismatch", out_mismatch, exp_mis(nexp));
          end
          last_hs = cyc;
          nexp++;
        end
      end else begin
        out_ready = 1;
      end
      prev_busy = busy;
      @(posedge clk); #1;
      cyc++;
    end
    start = 0;
    out_ready = 1;
    chk("done_seen", done, 1);
  endtask

  task automatic final_status(input int exp_cnt, input int exp_first, input int exp_cycles,
                              input int cyc_done);
    chk("scan_cycles", cyc_done, exp_cycles);
    chk("err_count", err_count, exp_cnt);
    chk("err_flag", err_flag, exp_cnt != 0);
    if (exp_cnt != 0) chk("first_err_addr", first_err_addr, exp_first);
    repeat (3) @(posedge clk);
    #1;
    chk("done_hold", done, 1);
    chk("count_hold", err_count, exp_cnt);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    vec_t tbl[7];
    int cdone, cnt, first, nc, len;
    tbl[0] = '{-1, 32'h0,          -1, 0, -1, -1, 0, 0,  BASE};      // clean, incl. wrap region
    tbl[1] = '{10, 32'h1,          -1, 0, -1, 40, 3, 10, BASE};      // single corrupt word
    tbl[2] = '{-1, 32'h0,          20, 5, -1, -1, 0, 0,  BASE + 5};  // 5-cycle stall at 20
    tbl[3] = '{10, 32'h1,          -1, 0, 30, -1, 0, 0,  0};         // reset mid-scan
    tbl[4] = '{-1, 32'h0,          -1, 0, -1, -1, 0, 0,  BASE};      // rescan after reset
    tbl[5] = '{63, 32'h8000_0000,  -1, 0, -1, -1, 1, 63, BASE};      // last entry only
    tbl[6] = '{0,  32'h1,          -1, 0, -1, -1, 1, 2,  BASE};      // corrupt seed

    rst = 1; start = 0; out_ready = 1;
    fill_fib();
    #1;
    chk("reset_raddr", raddr, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_mismatch", out_mismatch, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err_count", err_count, 0);
    chk("reset_err_flag", err_flag, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;

    for (int r = 0; r < 7; r++) begin
      fill_fib();
      if (tbl[r].corrupt_addr >= 0) mem[tbl[r].corrupt_addr] ^= tbl[r].mask;
      run_scan(tbl[r].stall_addr, tbl[r].stall_len, tbl[r].rst_addr, tbl[r].restart_addr, cdone);
      if (tbl[r].rst_addr < 0)
        final_status(tbl[r].exp_cnt, tbl[r].exp_first, tbl[r].exp_cycles, cdone);
    end

    for (int it = 0; it < 4; it++) begin
      fill_fib();
      nc = $urandom_range(1, 3);
      for (int j = 0; j < nc; j++)
        mem[$urandom_range(0, 63)] ^= ($urandom() | 32'h1);
      model(cnt, first);
      len = $urandom_range(0, 4);
      run_scan($urandom_range(SA, EA), len, -1, $urandom_range(SA, EA), cdone);
      final_status(cnt, first, BASE + len, cdone);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
